// File: rtl/game_timer_if.sv
// Command and display bundle between the game FSM / HUD and the elapsed-time counter.
interface game_timer_if;
  logic       game_clk;
  logic       start;
  logic       pause;
  logic       stop;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       sec_pulse;
  logic       saturated;

  modport master (
    output game_clk, start, pause, stop,
    input  sec_ones, sec_tens, min_ones, min_tens, running, sec_pulse, saturated
  );

  modport slave (
    input  game_clk, start, pause, stop,
    output sec_ones, sec_tens, min_ones, min_tens, running, sec_pulse, saturated
  );
endinterface

// File: rtl/game_timer.sv
// Sudoku elapsed-time counter: turns game_clk edges into seconds and keeps an mm:ss BCD value.
module game_timer #(
  parameter int TICKS_PER_SEC = 3,
  parameter int MAX_MIN       = 99
) (
  input logic         clk,
  input logic         reset,
  game_timer_if.slave bus
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             game_clk_d;
  logic             running;
  logic             sec_pulse;
  logic             saturated;

  // digit[0]=sec_ones, [1]=sec_tens, [2]=min_ones, [3]=min_tens
  logic [3:0] digit     [4];
  logic [3:0] digit_inc [4];
  logic [3:0] carry;
  logic       tick;
  logic       at_max;

  assign tick     = bus.game_clk ^ game_clk_d;
  assign carry[0] = 1'b1;
  assign at_max   = (digit[3] == MAX_MT) && (digit[2] == MAX_MO) &&
                    (digit[1] == 4'd5)   && (digit[0] == 4'd9);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
      assign digit_inc[gi] = !carry[gi]        ? digit[gi] :
                             (digit[gi] == LIM) ? 4'd0      : digit[gi] + 4'd1;
      if (gi < 3) begin : g_carry
        assign carry[gi+1] = carry[gi] && (digit[gi] == LIM);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      game_clk_d <= 1'b0;
      running    <= 1'b0;
      sec_pulse  <= 1'b0;
      saturated  <= 1'b0;
      for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
    end else begin
      game_clk_d <= bus.game_clk;
      sec_pulse  <= 1'b0;
      // Ignored commands do not count as active, so e.g. stop in IDLE never masks start.
      if (bus.stop && (state == RUN || state == PAUSE)) begin
        state   <= DONE;
        running <= 1'b0;
      end else if (bus.start) begin
        state     <= RUN;
        running   <= 1'b1;
        tick_cnt  <= '0;
        saturated <= 1'b0;
        for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
      end else if (bus.pause && state == RUN) begin
        state   <= PAUSE;
        running <= 1'b0;
      end else if (bus.pause && state == PAUSE) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (tick && state == RUN) begin
        if (tick_cnt == LAST_TICK) begin
          tick_cnt <= '0;
          if (at_max) begin
            state     <= DONE;
            running   <= 1'b0;
            saturated <= 1'b1;
          end else begin
            digit     <= digit_inc;
            sec_pulse <= 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.sec_ones  = digit[0];
  assign bus.sec_tens  = digit[1];
  assign bus.min_ones  = digit[2];
  assign bus.min_tens  = digit[3];
  assign bus.running   = running;
  assign bus.sec_pulse = sec_pulse;
  assign bus.saturated = saturated;

endmodule
